// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one single-outstanding memory bus between instruction fetch and data ports
module riscv_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_AW     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    instr_req,
    input  logic [BUS_AW-1:0]       instr_addr,
    output logic                    instr_gnt,
    output logic                    instr_rvalid,
    output logic [DATA_WIDTH-1:0]   instr_rdata,
    input  logic                    data_req,
    input  logic [BUS_AW-1:0]       data_addr,
    input  logic                    data_we,
    input  logic [DATA_WIDTH/8-1:0] data_be,
    input  logic [DATA_WIDTH-1:0]   data_wdata,
    output logic                    data_gnt,
    output logic                    data_rvalid,
    output logic [DATA_WIDTH-1:0]   data_rdata,
    output logic                    bus_req,
    output logic [BUS_AW-1:0]       bus_addr,
    output logic                    bus_we,
    output logic [DATA_WIDTH/8-1:0] bus_be,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic                    bus_gnt,
    input  logic                    bus_rvalid,
    input  logic [DATA_WIDTH-1:0]   bus_rdata,
    output logic                    busy
);
    localparam int SW = $clog2(STARVE_MAX + 2);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                    state_q, state_d;
    logic                      owner_q, owner_d;
    logic [BUS_AW-1:0]         addr_q, addr_d;
    logic                      we_q, we_d;
    logic [DATA_WIDTH/8-1:0]   be_q, be_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [SW-1:0]             starve_q, starve_d;
    logic                      pick_data;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        starve_d  = starve_q;
        pick_data = data_req && !(instr_req && starve_q == SMAX);
        case (state_q)
            IDLE: if (instr_req || data_req) begin
                state_d  = REQ;
                owner_d  = pick_data;
                addr_d   = pick_data ? data_addr : instr_addr;
                we_d     = pick_data && data_we;
                be_d     = pick_data ? data_be : '1;
                wdata_d  = pick_data ? data_wdata : '0;
                starve_d = (pick_data && instr_req) ? ((starve_q == SMAX) ? SMAX : starve_q + 1'b1) : '0;
            end
            REQ:     if (bus_gnt) state_d = RESP;
            RESP:    if (bus_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            starve_q <= starve_d;
        end
    end

    // owner_q = 1 means the data port owns the current transaction
    assign bus_req      = state_q == REQ;
    assign bus_addr     = addr_q;
    assign bus_we       = we_q;
    assign bus_be       = be_q;
    assign bus_wdata    = wdata_q;
    assign busy         = state_q != IDLE;
    assign instr_gnt    = bus_req && !owner_q && bus_gnt;
    assign data_gnt     = bus_req && owner_q && bus_gnt;
    assign instr_rvalid = state_q == RESP && !owner_q && bus_rvalid;
    assign data_rvalid  = state_q == RESP && owner_q && bus_rvalid;
    assign instr_rdata  = (state_q == RESP && !owner_q) ? bus_rdata : '0;
    assign data_rdata   = (state_q == RESP && owner_q) ? bus_rdata : '0;
endmodule
